// File: rtl/bomberman_keyboard_decoder.sv
// PS/2 set-2 scancode parser that turns keyboard bytes into held-key flags
// and movement/bomb controls for the two Bomberman players.
module bomberman_keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic       p1_bomb,
    output logic       p1_xdir,
    output logic       p1_xmov,
    output logic       p1_ydir,
    output logic       p1_ymov,
    output logic       p2_bomb,
    output logic       p2_xdir,
    output logic       p2_xmov,
    output logic       p2_ydir,
    output logic       p2_ymov,
    output logic [9:0] key_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(PAUSE_SKIP + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SKIP_LOAD  = SW'(PAUSE_SKIP);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [SW-1:0] skip_cnt;
    logic          ext_code;
    logic          is_ignored;
    logic          do_make;
    logic          do_break;
    logic [9:0]    key_mask;

    // One-hot position of a mapped key in key_state; keypad codes map to nothing.
    function automatic logic [9:0] decode_key(input logic [7:0] code, input logic ext);
        logic [9:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                8'h1D:   m[0] = 1'b1;
                8'h1B:   m[1] = 1'b1;
                8'h1C:   m[2] = 1'b1;
                8'h23:   m[3] = 1'b1;
                8'h29:   m[4] = 1'b1;
                8'h5A:   m[9] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h75:   m[5] = 1'b1;
                8'h72:   m[6] = 1'b1;
                8'h6B:   m[7] = 1'b1;
                8'h74:   m[8] = 1'b1;
                8'h5A:   m[9] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        ext_code   = (state == EXT) || (state == EXTBRK);
        key_mask   = decode_key(scancode, ext_code);
        is_ignored = scancode inside {8'hFA, 8'hAA, 8'hFE, 8'h00, 8'hFF};
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (scancode_valid) begin
            case (state)
                IDLE:        do_make  = !is_ignored && !(scancode inside {8'hE0, 8'hF0, 8'hE1});
                EXT:         do_make  = !(scancode inside {8'hE0, 8'hF0});
                BRK, EXTBRK: do_break = 1'b1;
                default:     ;
            endcase
        end
    end

    // A bomb pulse coincides with its key_state bit rising, so repeats while held are silent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            skip_cnt  <= '0;
            key_state <= '0;
            p1_bomb   <= 1'b0;
            p2_bomb   <= 1'b0;
        end else begin
            p1_bomb <= do_make && key_mask[4] && !key_state[4];
            p2_bomb <= do_make && key_mask[9] && !key_state[9];
            if (do_make)
                key_state <= key_state | key_mask;
            else if (do_break)
                key_state <= key_state & ~key_mask;

            if (scancode_valid) begin
                timer <= '0;
                case (state)
                    IDLE: begin
                        if (scancode == 8'hE0)
                            state <= EXT;
                        else if (scancode == 8'hF0)
                            state <= BRK;
                        else if (scancode == 8'hE1) begin
                            state    <= SKIP;
                            skip_cnt <= SKIP_LOAD;
                        end
                    end
                    EXT: begin
                        if (scancode == 8'hF0)
                            state <= EXTBRK;
                        else if (scancode != 8'hE0)
                            state <= IDLE;
                    end
                    BRK, EXTBRK: state <= IDLE;
                    SKIP: begin
                        skip_cnt <= skip_cnt - SW'(1);
                        if (skip_cnt <= SW'(1))
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (timer == TIMER_LAST) begin
                    state <= IDLE;
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    // Opposite keys cancel: no movement and direction forced to 0.
    assign p1_xmov = key_state[2] ^ key_state[3];
    assign p1_xdir = key_state[3] & ~key_state[2];
    assign p1_ymov = key_state[0] ^ key_state[1];
    assign p1_ydir = key_state[1] & ~key_state[0];
    assign p2_xmov = key_state[7] ^ key_state[8];
    assign p2_xdir = key_state[8] & ~key_state[7];
    assign p2_ymov = key_state[5] ^ key_state[6];
    assign p2_ydir = key_state[6] & ~key_state[5];

endmodule

// File: tb/tb_bomberman_keyboard_decoder.sv
// Table-driven scoreboard bench for the keyboard decoder: each byte pushes its
// expected key/bomb/movement state, popped and compared one cycle later.
module tb_bomberman_keyboard_decoder;

    localparam int TIMEOUT = 40;
    localparam int SKIP    = 7;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       p1_bomb, p1_xdir, p1_xmov, p1_ydir, p1_ymov;
    logic       p2_bomb, p2_xdir, p2_xmov, p2_ydir, p2_ymov;
    logic [9:0] key_state;
    logic [7:0] mov_actual;

    typedef struct {
        logic [7:0] code;
        logic [9:0] keys;
        logic [1:0] bombs;
        logic [7:0] mov;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] keys;
        logic [1:0] bombs;
        logic [7:0] mov;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   vectors_applied = 0;
    int   miscompares = 0;

    bomberman_keyboard_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .PAUSE_SKIP(SKIP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .scancode(scancode),
        .scancode_valid(scancode_valid),
        .p1_bomb(p1_bomb),
        .p1_xdir(p1_xdir),
        .p1_xmov(p1_xmov),
        .p1_ydir(p1_ydir),
        .p1_ymov(p1_ymov),
        .p2_bomb(p2_bomb),
        .p2_xdir(p2_xdir),
        .p2_xmov(p2_xmov),
        .p2_ydir(p2_ydir),
        .p2_ymov(p2_ymov),
        .key_state(key_state)
    );

    always #10 clock = ~clock;

    assign mov_actual = {p2_xmov, p2_xdir, p2_ymov, p2_ydir, p1_xmov, p1_xdir, p1_ymov, p1_ydir};

    function automatic void addVec(input logic [7:0] code, input logic [9:0] keys,
                                   input logic [1:0] bombs, input logic [7:0] mov);
        vec_t v;
        v.code  = code;
        v.keys  = keys;
        v.bombs = bombs;
        v.mov   = mov;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput();
        exp_t e;
        vectors_applied++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: no expected entry to compare");
            return;
        end
        e = sb.pop_front();
        if (key_state !== e.keys || {p2_bomb, p1_bomb} !== e.bombs || mov_actual !== e.mov) begin
            miscompares++;
            $display("[TB] FAIL %s: got key_state=%h bombs=%b mov=%b, expected key_state=%h bombs=%b mov=%b",
                     e.name, key_state, {p2_bomb, p1_bomb}, mov_actual, e.keys, e.bombs, e.mov);
        end
        if (e.bombs != 2'b00) begin
            @(negedge clock);
            vectors_applied++;
            if ({p2_bomb, p1_bomb} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL %s_pulse_width: got bombs=%b one cycle later, expected 00",
                         e.name, {p2_bomb, p1_bomb});
            end
        end
    endtask

    task automatic checkNow(input string name, input logic [9:0] keys,
                            input logic [1:0] bombs, input logic [7:0] mov);
        exp_t e;
        e.name  = name;
        e.keys  = keys;
        e.bombs = bombs;
        e.mov   = mov;
        sb.push_back(e);
        checkOutput();
    endtask

    // Called on a falling edge: the byte is taken at the next rising edge and checked one half-cycle later.
    task automatic applyStimulus(input string name, input logic [7:0] code, input logic [9:0] keys,
                                 input logic [1:0] bombs, input logic [7:0] mov);
        exp_t e;
        scancode       = code;
        scancode_valid = 1'b1;
        e.name  = name;
        e.keys  = keys;
        e.bombs = bombs;
        e.mov   = mov;
        sb.push_back(e);
        @(negedge clock);
        scancode_valid = 1'b0;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        scancode       = 8'h00;
        scancode_valid = 1'b0;

        addVec(8'h1D, 10'h001, 2'b00, 8'b0000_0010);
        addVec(8'hF0, 10'h001, 2'b00, 8'b0000_0010);
        addVec(8'h1D, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h74, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'h74, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'h29, 10'h110, 2'b01, 8'b1100_0000);
        addVec(8'h29, 10'h110, 2'b00, 8'b1100_0000);
        addVec(8'h29, 10'h110, 2'b00, 8'b1100_0000);
        addVec(8'hF0, 10'h110, 2'b00, 8'b1100_0000);
        addVec(8'h29, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'h29, 10'h110, 2'b01, 8'b1100_0000);
        addVec(8'hF0, 10'h110, 2'b00, 8'b1100_0000);
        addVec(8'h29, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'hE0, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'hF0, 10'h100, 2'b00, 8'b1100_0000);
        addVec(8'h74, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h1C, 10'h004, 2'b00, 8'b0000_1000);
        addVec(8'h23, 10'h00C, 2'b00, 8'b0000_0000);
        addVec(8'hF0, 10'h00C, 2'b00, 8'b0000_0000);
        addVec(8'h1C, 10'h008, 2'b00, 8'b0000_1100);
        addVec(8'h1B, 10'h00A, 2'b00, 8'b0000_1111);
        addVec(8'hF0, 10'h00A, 2'b00, 8'b0000_1111);
        addVec(8'h23, 10'h002, 2'b00, 8'b0000_0011);
        addVec(8'h1D, 10'h003, 2'b00, 8'b0000_0000);
        addVec(8'hF0, 10'h003, 2'b00, 8'b0000_0000);
        addVec(8'h1D, 10'h002, 2'b00, 8'b0000_0011);
        addVec(8'hF0, 10'h002, 2'b00, 8'b0000_0011);
        addVec(8'h1B, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h5A, 10'h200, 2'b10, 8'b0000_0000);
        addVec(8'hE0, 10'h200, 2'b00, 8'b0000_0000);
        addVec(8'hF0, 10'h200, 2'b00, 8'b0000_0000);
        addVec(8'h5A, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h5A, 10'h200, 2'b10, 8'b0000_0000);
        addVec(8'hF0, 10'h200, 2'b00, 8'b0000_0000);
        addVec(8'h5A, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hFA, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h72, 10'h040, 2'b00, 8'b0011_0000);
        addVec(8'hE0, 10'h040, 2'b00, 8'b0011_0000);
        addVec(8'h6B, 10'h0C0, 2'b00, 8'b1011_0000);
        addVec(8'hE0, 10'h0C0, 2'b00, 8'b1011_0000);
        addVec(8'hF0, 10'h0C0, 2'b00, 8'b1011_0000);
        addVec(8'h72, 10'h080, 2'b00, 8'b1000_0000);
        addVec(8'hE0, 10'h080, 2'b00, 8'b1000_0000);
        addVec(8'hF0, 10'h080, 2'b00, 8'b1000_0000);
        addVec(8'h6B, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h75, 10'h020, 2'b00, 8'b0010_0000);
        addVec(8'hE0, 10'h020, 2'b00, 8'b0010_0000);
        addVec(8'hF0, 10'h020, 2'b00, 8'b0010_0000);
        addVec(8'h75, 10'h000, 2'b00, 8'b0000_0000);
        // Pause sequence: the seven bytes after E1 must have no key effect.
        addVec(8'hE1, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h14, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h77, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE1, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hF0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h14, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hF0, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h77, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h1B, 10'h002, 2'b00, 8'b0000_0011);
        addVec(8'hF0, 10'h002, 2'b00, 8'b0000_0011);
        addVec(8'h1B, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'hE1, 10'h000, 2'b00, 8'b0000_0000);
        for (int i = 0; i < SKIP; i++)
            addVec(8'h1D, 10'h000, 2'b00, 8'b0000_0000);
        addVec(8'h1D, 10'h001, 2'b00, 8'b0000_0010);
        addVec(8'hF0, 10'h001, 2'b00, 8'b0000_0010);
        addVec(8'h1D, 10'h000, 2'b00, 8'b0000_0000);

        repeat (3) @(negedge clock);
        checkNow("reset_held", 10'h000, 2'b00, 8'h00);
        reset = 1'b0;
        @(negedge clock);
        checkNow("reset_released", 10'h000, 2'b00, 8'h00);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus($sformatf("vec%0d_%h", i, vecs[i].code), vecs[i].code,
                          vecs[i].keys, vecs[i].bombs, vecs[i].mov);

        applyStimulus("ext_prefix_a", 8'hE0, 10'h000, 2'b00, 8'h00);
        idleCycles(TIMEOUT - 1);
        applyStimulus("ext_last_cycle_75", 8'h75, 10'h020, 2'b00, 8'b0010_0000);
        applyStimulus("ext_rel_e0", 8'hE0, 10'h020, 2'b00, 8'b0010_0000);
        applyStimulus("ext_rel_f0", 8'hF0, 10'h020, 2'b00, 8'b0010_0000);
        applyStimulus("ext_rel_75", 8'h75, 10'h000, 2'b00, 8'h00);
        applyStimulus("ext_prefix_b", 8'hE0, 10'h000, 2'b00, 8'h00);
        idleCycles(TIMEOUT);
        applyStimulus("ext_timed_out_75", 8'h75, 10'h000, 2'b00, 8'h00);
        applyStimulus("brk_prefix", 8'hF0, 10'h000, 2'b00, 8'h00);
        idleCycles(TIMEOUT);
        applyStimulus("brk_timed_out_1d", 8'h1D, 10'h001, 2'b00, 8'b0000_0010);
        applyStimulus("brk_rel_f0", 8'hF0, 10'h001, 2'b00, 8'b0000_0010);
        applyStimulus("brk_rel_1d", 8'h1D, 10'h000, 2'b00, 8'h00);

        applyStimulus("mid_make_23", 8'h23, 10'h008, 2'b00, 8'b0000_1100);
        applyStimulus("mid_f0", 8'hF0, 10'h008, 2'b00, 8'b0000_1100);
        reset = 1'b1;
        @(negedge clock);
        checkNow("mid_reset", 10'h000, 2'b00, 8'h00);
        reset = 1'b0;
        applyStimulus("post_reset_23_make", 8'h23, 10'h008, 2'b00, 8'b0000_1100);
        applyStimulus("post_reset_f0", 8'hF0, 10'h008, 2'b00, 8'b0000_1100);
        applyStimulus("post_reset_23_break", 8'h23, 10'h000, 2'b00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
